// File: rtl/spmv_vec_fetch.sv
// Command-driven sequential vector reader: one single-beat 32-bit AXI read per element,
// credit-limited against an internal R FIFO, re-emitted in order as an AXI-Stream with tlast.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | cmd_ready=1, waiting for a command
//   S_RUN   | issuing AR requests, stream drains concurrently
//   S_DRAIN | all ARs accepted, waiting for the tlast beat to leave
module spmv_vec_fetch #(
    parameter int ADDR_WIDTH      = 48,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 1,
    parameter int CNT_WIDTH       = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [CNT_WIDTH-1:0]  cmd_count,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,

    output logic                  busy,
    output logic                  done,
    output logic                  rresp_err
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CRW   = PTR_W + 1;
    localparam logic [CRW-1:0] MAX_CR = CRW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] count_r;
    logic [CNT_WIDTH-1:0] issued;
    logic [CNT_WIDTH-1:0] received;
    logic [CRW-1:0]       credit;

    logic [DATA_WIDTH:0]  fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CRW-1:0]       fifo_cnt;

    logic                 cmd_hs;
    logic                 ar_hs;
    logic                 r_wr;
    logic                 pop;
    logic                 last_pop;
    logic [CNT_WIDTH-1:0] issued_next;
    logic [CRW-1:0]       credit_next;
    logic                 can_issue;
    logic                 r_last_flag;
    logic                 unused_rlast;

    assign m_axi_arid    = '0;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    // Credits reserve a FIFO slot for every outstanding AR, so R never needs backpressure.
    assign m_axi_rready  = 1'b1;
    assign unused_rlast  = m_axi_rlast;

    assign cmd_hs   = cmd_valid & cmd_ready;
    assign ar_hs    = m_axi_arvalid & m_axi_arready;
    assign r_wr     = m_axi_rvalid;
    assign pop      = m_axis_tvalid & m_axis_tready;
    assign last_pop = pop & m_axis_tlast;

    assign m_axis_tvalid = (fifo_cnt != '0);
    assign m_axis_tdata  = fifo_mem[rd_ptr][DATA_WIDTH:1];
    assign m_axis_tlast  = m_axis_tvalid & fifo_mem[rd_ptr][0];

    assign r_last_flag = (received == count_r - CNT_WIDTH'(1));

    always_comb begin
        issued_next = issued;
        credit_next = credit;
        if (ar_hs) begin
            issued_next = issued + CNT_WIDTH'(1);
        end
        if (ar_hs && !pop) begin
            credit_next = credit + CRW'(1);
        end else if (!ar_hs && pop) begin
            credit_next = credit - CRW'(1);
        end
        can_issue = (state == S_RUN) && (issued_next < count_r) && (credit_next < MAX_CR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cmd_ready     <= 1'b0;
            count_r       <= '0;
            issued        <= '0;
            received      <= '0;
            credit        <= '0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rresp_err     <= 1'b0;
        end else begin
            done   <= 1'b0;
            credit <= credit_next;
            if (ar_hs) begin
                issued       <= issued_next;
                m_axi_araddr <= m_axi_araddr + ADDR_WIDTH'(4);
            end
            if (r_wr) begin
                received <= received + CNT_WIDTH'(1);
                if (m_axi_rresp != 2'b00) begin
                    rresp_err <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_hs) begin
                        count_r      <= cmd_count;
                        issued       <= '0;
                        received     <= '0;
                        m_axi_araddr <= cmd_addr;
                        if (cmd_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state         <= S_RUN;
                            busy          <= 1'b1;
                            cmd_ready     <= 1'b0;
                            m_axi_arvalid <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // Hold arvalid/araddr until accepted; otherwise re-evaluate credit.
                    if (!m_axi_arvalid || m_axi_arready) begin
                        m_axi_arvalid <= can_issue;
                    end
                    if (ar_hs && (issued_next == count_r)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    m_axi_arvalid <= 1'b0;
                    if (last_pop) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (r_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (r_wr && !pop) begin
                fifo_cnt <= fifo_cnt + CRW'(1);
            end else if (!r_wr && pop) begin
                fifo_cnt <= fifo_cnt - CRW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_wr) begin
            fifo_mem[wr_ptr] <= {m_axi_rdata, r_last_flag};
        end
    end

endmodule

// File: tb/tb_spmv_vec_fetch.sv
// Directed bench for spmv_vec_fetch: behavioural memory returns address-as-data,
// stream and AR traffic are logged and compared against hand-computed expectations.
module tb_spmv_vec_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [47:0] cmd_addr;
    logic [31:0] cmd_count;
    logic [0:0]  m_axi_arid;
    logic [47:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;
    logic        rresp_err;

    spmv_vec_fetch dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_count(cmd_count),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done), .rresp_err(rresp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] addr;
        int          due;
    } rd_t;

    rd_t         pend[$];
    rd_t         nr;
    rd_t         rhead;
    logic [47:0] ar_log[$];
    logic [31:0] s_data[$];
    logic        s_last[$];
    int          done_cnt = 0;
    int          cyc = 0;
    int          lat = 2;
    logic [47:0] err_addr;
    int          checks = 0;
    int          failures = 0;

    // Memory model and traffic logs; samples pre-edge values at posedge.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pend.delete();
        end else begin
            if (m_axi_arvalid && m_axi_arready) begin
                nr.addr = m_axi_araddr;
                nr.due  = cyc + lat;
                pend.push_back(nr);
                ar_log.push_back(m_axi_araddr);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                s_data.push_back(m_axis_tdata);
                s_last.push_back(m_axis_tlast);
            end
            if (done) done_cnt++;
        end
    end

    always @(negedge clk) begin
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            rhead        = pend.pop_front();
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = rhead.addr[31:0];
            m_axi_rresp  = (rhead.addr == err_addr) ? 2'b10 : 2'b00;
        end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rdata  = '0;
            m_axi_rresp  = 2'b00;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        ar_log.delete();
        s_data.delete();
        s_last.delete();
    endtask

    task automatic send_cmd(input logic [47:0] addr, input logic [31:0] cnt);
        @(negedge clk);
        check("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_count = cnt;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, done_cnt != start, 1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_cmd_ready"}, cmd_ready, 0);
        check({pfx, "_arvalid"}, m_axi_arvalid, 0);
        check({pfx, "_araddr"}, m_axi_araddr, 0);
        check({pfx, "_tvalid"}, m_axis_tvalid, 0);
        check({pfx, "_tlast"}, m_axis_tlast, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_rresp_err"}, rresp_err, 0);
        check({pfx, "_rready"}, m_axi_rready, 1);
    endtask

    task automatic check_seq(input string tag, input logic [47:0] base, input int n);
        check({tag, "_ar_count"}, ar_log.size(), n);
        check({tag, "_beat_count"}, s_data.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < ar_log.size()) check($sformatf("%s_araddr%0d", tag, i), ar_log[i], base + 48'(4 * i));
            if (i < s_data.size()) begin
                check($sformatf("%s_tdata%0d", tag, i), s_data[i], base[31:0] + 32'(4 * i));
                check($sformatf("%s_tlast%0d", tag, i), s_last[i], (i == n - 1) ? 1 : 0);
            end
        end
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        cmd_valid     = 1'b0;
        cmd_addr      = '0;
        cmd_count     = '0;
        m_axi_arready = 1'b1;
        m_axi_rlast   = 1'b1;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axis_tready = 1'b1;
        err_addr      = '1;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        check("arlen", m_axi_arlen, 0);
        check("arsize", m_axi_arsize, 3'b010);
        check("arburst", m_axi_arburst, 2'b01);
        check("arid", m_axi_arid, 0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_rst", cmd_ready, 1);

        // Basic 4-element read
        clear_logs();
        send_cmd(48'h1000, 4);
        check("basic_busy_after_accept", busy, 1);
        check("basic_arvalid_after_accept", m_axi_arvalid, 1);
        check("basic_araddr_first", m_axi_araddr, 48'h1000);
        wait_done(100, "basic_done_seen");
        @(negedge clk);
        check("basic_busy_fell", busy, 0);
        check("basic_done_single", done, 0);
        check("basic_cmd_ready", cmd_ready, 1);
        check_seq("basic", 48'h1000, 4);

        // Zero count
        clear_logs();
        send_cmd(48'h2000, 0);
        check("zero_done_pulse", done, 1);
        check("zero_cmd_ready", cmd_ready, 1);
        check("zero_busy", busy, 0);
        check("zero_arvalid", m_axi_arvalid, 0);
        @(negedge clk);
        check("zero_done_drop", done, 0);
        repeat (5) @(negedge clk);
        check("zero_no_ar", ar_log.size(), 0);
        check("zero_no_beat", s_data.size(), 0);
        check("zero_tvalid", m_axis_tvalid, 0);

        // Backpressure: credits cap outstanding ARs at 8
        clear_logs();
        m_axis_tready = 1'b0;
        send_cmd(48'h3000, 20);
        repeat (40) @(negedge clk);
        check("bp_ar_capped", ar_log.size(), 8);
        check("bp_arvalid_low", m_axi_arvalid, 0);
        check("bp_tvalid", m_axis_tvalid, 1);
        check("bp_head_data", m_axis_tdata, 32'h3000);
        m_axis_tready = 1'b1;
        wait_done(400, "bp_done_seen");
        check_seq("bp", 48'h3000, 20);

        // AR stall on second request
        clear_logs();
        send_cmd(48'h4000, 6);
        n = 0;
        while (ar_log.size() < 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_first_ar", ar_log.size(), 1);
        m_axi_arready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_arvalid%0d", i), m_axi_arvalid, 1);
            check($sformatf("stall_araddr%0d", i), m_axi_araddr, 48'h4004);
        end
        m_axi_arready = 1'b1;
        wait_done(200, "stall_done_seen");
        check_seq("stall", 48'h4000, 6);

        // Error response on third element
        clear_logs();
        err_addr = 48'h5008;
        check("err_clear_before", rresp_err, 0);
        send_cmd(48'h5000, 4);
        wait_done(100, "err_done_seen");
        check("err_flag", rresp_err, 1);
        check_seq("err", 48'h5000, 4);
        err_addr = '1;
        clear_logs();
        send_cmd(48'h5100, 2);
        wait_done(100, "sticky_done_seen");
        check("err_sticky", rresp_err, 1);
        check_seq("sticky", 48'h5100, 2);

        // Reset mid-command
        clear_logs();
        m_axis_tready = 1'b0;
        send_cmd(48'h6000, 16);
        repeat (12) @(negedge clk);
        check("midrst_busy", busy, 1);
        check("midrst_tvalid", m_axis_tvalid, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge clk);
        check("midrst_cmd_ready", cmd_ready, 1);
        clear_logs();
        send_cmd(48'h7000, 3);
        wait_done(100, "post_rst_done_seen");
        check_seq("post_rst", 48'h7000, 3);
        check("post_rst_err_clear", rresp_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
